// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between an instruction source and the control sequencer.
// The master modport issues instructions; the slave modport is the sequencer side.
interface control_sequencer_if #(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned FUNC_W     = 4
);
    localparam int unsigned CodeW = 3 + 3 * REG_ADDR_W;

    logic                  start;
    logic [CodeW-1:0]      machine_code;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [2:0]            step;
    logic                  data_enable;
    logic                  reg_we;
    logic [REG_ADDR_W-1:0] reg_wsel;
    logic                  reg_re;
    logic [REG_ADDR_W-1:0] reg_rsel;
    logic [2:0]            alu_en;
    logic [FUNC_W-1:0]     func_sel;

    modport master (
        output start, machine_code,
        input  busy, done, error, step, data_enable, reg_we, reg_wsel,
        input  reg_re, reg_rsel, alu_en, func_sel
    );

    modport slave (
        input  start, machine_code,
        output busy, done, error, step, data_enable, reg_we, reg_wsel,
        output reg_re, reg_rsel, alu_en, func_sel
    );
endinterface

// File: rtl/control_sequencer.sv
// Three-state micro-sequencer turning one latched instruction into register/ALU strobes.
// Define SEQ_ILLEGAL_TRAP_EN to make opcode 111 raise a sticky error flag after it completes.
module control_sequencer #(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned FUNC_W     = 4
) (
    input logic              clock,
    input logic              reset,
    control_sequencer_if.slave bus
);
    localparam int unsigned CodeW = 3 + 3 * REG_ADDR_W;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e                state_q, state_d;
    logic [CodeW-1:0]      instr_q, instr_d;
    logic [2:0]            step_q, step_d;
    logic [2:0]            opcode;
    logic [2:0]            fcode;
    logic [2:0]            last_step;
    logic [REG_ADDR_W-1:0] p1, p2, p3;

    assign opcode = instr_q[CodeW-1 -: 3];
    assign p1     = instr_q[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign p2     = instr_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign p3     = instr_q[REG_ADDR_W-1:0];
    assign fcode  = opcode - 3'd2;

    always_comb begin
        last_step = 3'd1;
        case (opcode)
            3'b010, 3'b011, 3'b100, 3'b101: last_step = 3'd3;
            3'b110:                         last_step = 3'd2;
            default:                        last_step = 3'd1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            instr_q <= '0;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        step_d  = step_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    instr_d = bus.machine_code;
                    step_d  = 3'd1;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (step_q == last_step) begin
                    step_d  = 3'd0;
                    state_d = StDone;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic error_q, error_d;

    // Set when an illegal opcode finishes; cleared only by the next accepted instruction.
    always_comb begin
        error_d = error_q;
        if (state_q == StIdle && bus.start) begin
            error_d = 1'b0;
        end else if (state_q == StExec && step_q == last_step && opcode == 3'b111) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    always_comb begin
        bus.busy        = (state_q != StIdle);
        bus.done        = (state_q == StDone);
        bus.step        = step_q;
        bus.data_enable = 1'b0;
        bus.reg_we      = 1'b0;
        bus.reg_wsel    = '0;
        bus.reg_re      = 1'b0;
        bus.reg_rsel    = '0;
        bus.alu_en      = 3'b000;
        bus.func_sel    = '0;
        if (state_q == StExec) begin
            if (opcode >= 3'b010 && opcode <= 3'b110) begin
                bus.func_sel = {{(FUNC_W-3){1'b0}}, fcode};
            end
            case (opcode)
                3'b000: begin
                    if (step_q == 3'd1) begin
                        bus.data_enable = 1'b1;
                        bus.reg_we      = 1'b1;
                        bus.reg_wsel    = p1;
                    end
                end
                3'b001: begin
                    if (step_q == 3'd1) begin
                        bus.reg_re   = 1'b1;
                        bus.reg_rsel = p2;
                        bus.reg_we   = 1'b1;
                        bus.reg_wsel = p1;
                    end
                end
                3'b010, 3'b011, 3'b100, 3'b101: begin
                    case (step_q)
                        3'd1: begin
                            bus.reg_re   = 1'b1;
                            bus.reg_rsel = p2;
                            bus.alu_en   = 3'b001;
                        end
                        3'd2: begin
                            bus.reg_re   = 1'b1;
                            bus.reg_rsel = p3;
                            bus.alu_en   = 3'b010;
                        end
                        3'd3: begin
                            bus.alu_en   = 3'b100;
                            bus.reg_we   = 1'b1;
                            bus.reg_wsel = p1;
                        end
                        default: ;
                    endcase
                end
                3'b110: begin
                    case (step_q)
                        3'd1: begin
                            bus.reg_re   = 1'b1;
                            bus.reg_rsel = p2;
                            bus.alu_en   = 3'b001;
                        end
                        3'd2: begin
                            bus.alu_en   = 3'b100;
                            bus.reg_we   = 1'b1;
                            bus.reg_wsel = p1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule
